// File: rtl/rast_pipe_pkg.sv
// rast_pipe_pkg: default shape constants shared by the rasterizer pipeline registers
package rast_pipe_pkg;
  localparam int SIGFIG = 24;
  localparam int RADIX = 10;
  localparam int VERTS = 3;
  localparam int AXIS = 3;
  localparam int COLORS = 3;
endpackage

// File: rtl/dff_pipe_array_if.sv
// dff_pipe_array_if: enable plus 2-D data in/out bundle for the pipeline delay line
interface dff_pipe_array_if
  import rast_pipe_pkg::*;
#(
  parameter int WIDTH = SIGFIG,
  parameter int ARRAY_SIZE1 = VERTS,
  parameter int ARRAY_SIZE2 = AXIS
);
  logic en;
  logic [WIDTH-1:0] in [ARRAY_SIZE1][ARRAY_SIZE2];
  logic [WIDTH-1:0] out [ARRAY_SIZE1][ARRAY_SIZE2];
  modport master (output en, in, input out);
  modport slave (input en, in, output out);
endinterface

// File: rtl/dff.sv
// dff: scalar-word form of dff_pipe_array (1x1 array)
module dff #(
  parameter int WIDTH = 24,
  parameter int PIPE_DEPTH = 1,
  parameter bit RETIME_STATUS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  dff_pipe_array_if #(.WIDTH(WIDTH), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1)) b ();
  assign b.en = en;
  assign b.in[0][0] = in;
  assign out = b.out[0][0];
  dff_pipe_array #(
    .WIDTH(WIDTH), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1),
    .PIPE_DEPTH(PIPE_DEPTH), .RETIME_STATUS(RETIME_STATUS)
  ) u_pipe (.clk(clk), .reset(reset), .bus(b.slave));
endmodule

// File: rtl/dff2.sv
// dff2: 1-D form of dff_pipe_array (1 x ARRAY_SIZE array)
module dff2 #(
  parameter int WIDTH = 24,
  parameter int ARRAY_SIZE = 3,
  parameter int PIPE_DEPTH = 1,
  parameter bit RETIME_STATUS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in [ARRAY_SIZE],
  output logic [WIDTH-1:0] out [ARRAY_SIZE]
);
  dff_pipe_array_if #(.WIDTH(WIDTH), .ARRAY_SIZE1(1), .ARRAY_SIZE2(ARRAY_SIZE)) b ();
  assign b.en = en;
  assign b.in[0] = in;
  assign out = b.out[0];
  dff_pipe_array #(
    .WIDTH(WIDTH), .ARRAY_SIZE1(1), .ARRAY_SIZE2(ARRAY_SIZE),
    .PIPE_DEPTH(PIPE_DEPTH), .RETIME_STATUS(RETIME_STATUS)
  ) u_pipe (.clk(clk), .reset(reset), .bus(b.slave));
endmodule

// File: rtl/dff_stage_elem.sv
// dff_stage_elem: one WIDTH-bit stage flop with sync clear, enable and optional retime tag
module dff_stage_elem #(
  parameter int WIDTH = 24,
  parameter bit RETIME_STATUS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (RETIME_STATUS) begin : g_rt
    (* retiming_allowed = "yes" *) logic [WIDTH-1:0] r;
    always_ff @(posedge clk) r <= reset ? '0 : en ? d : r;
    assign q = r;
  end else begin : g_fixed
    logic [WIDTH-1:0] r;
    always_ff @(posedge clk) r <= reset ? '0 : en ? d : r;
    assign q = r;
  end
endmodule

// File: rtl/dff_pipe_array.sv
// dff_pipe_array: delays a 2-D word array by PIPE_DEPTH enabled clocks with sync clear
module dff_pipe_array
  import rast_pipe_pkg::*;
#(
  parameter int WIDTH = SIGFIG,
  parameter int ARRAY_SIZE1 = VERTS,
  parameter int ARRAY_SIZE2 = AXIS,
  parameter int PIPE_DEPTH = 1,
  parameter bit RETIME_STATUS = 1'b0
) (
  input logic clk,
  input logic reset,
  dff_pipe_array_if.slave bus
);
  if (PIPE_DEPTH == 0) begin : g_comb
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset, bus.en};
    assign bus.out = bus.in;
  end else begin : g_pipe
    logic [WIDTH-1:0] stg [1:PIPE_DEPTH][ARRAY_SIZE1][ARRAY_SIZE2];
    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_d
      for (genvar i = 0; i < ARRAY_SIZE1; i++) begin : g_i
        for (genvar j = 0; j < ARRAY_SIZE2; j++) begin : g_j
          logic [WIDTH-1:0] d;
          if (k == 0) begin : g_head
            assign d = bus.in[i][j];
          end else begin : g_tail
            assign d = stg[k][i][j];
          end
          dff_stage_elem #(.WIDTH(WIDTH), .RETIME_STATUS(RETIME_STATUS)) u_elem (
            .clk(clk), .reset(reset), .en(bus.en), .d(d), .q(stg[k+1][i][j])
          );
        end
      end
    end
    assign bus.out = stg[PIPE_DEPTH];
  end
endmodule

// File: tb/tb_dff_pipe_array.sv
// tb_dff_pipe_array: directed checks of latency, clear, stall, depth skew, pass-through and bit-exactness
module tb_dff_pipe_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  dff_pipe_array_if #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3)) b3 ();
  dff_pipe_array_if #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3)) b0 ();
  dff_pipe_array_if #(.WIDTH(24), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1)) b1 ();
  dff_pipe_array #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(3), .RETIME_STATUS(1'b1))
    u3 (.clk(clk), .reset(rst), .bus(b3.slave));
  dff_pipe_array #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(0))
    u0 (.clk(clk), .reset(rst), .bus(b0.slave));
  dff_pipe_array #(.WIDTH(24), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(1))
    u1 (.clk(clk), .reset(rst), .bus(b1.slave));
  logic s_en = 1'b0;
  logic [7:0] s_in = '0, s_out;
  dff #(.WIDTH(8), .PIPE_DEPTH(2)) us (.clk(clk), .reset(rst), .en(s_en), .in(s_in), .out(s_out));
  logic v_en = 1'b0;
  logic [0:0] v_in = '0, v_out;
  dff #(.WIDTH(1), .PIPE_DEPTH(1)) uv (.clk(clk), .reset(rst), .en(v_en), .in(v_in), .out(v_out));
  logic r_en = 1'b0;
  logic [15:0] r_in [2];
  logic [15:0] o2 [2];
  logic [15:0] o3 [2];
  dff2 #(.WIDTH(16), .ARRAY_SIZE(2), .PIPE_DEPTH(2)) ud2 (.clk(clk), .reset(rst), .en(r_en), .in(r_in), .out(o2));
  dff2 #(.WIDTH(16), .ARRAY_SIZE(2), .PIPE_DEPTH(3)) ud3 (.clk(clk), .reset(rst), .en(r_en), .in(r_in), .out(o3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    b3.en = 1'b1;
    b1.en = 1'b1;
    s_en = 1'b1;
    v_en = 1'b1;
    r_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        tests++;
        if (b3.out[i][j] !== 24'h0) begin
          fails++;
          $display("FAIL reset_u3[%0d][%0d] got %h want 0", i, j, b3.out[i][j]);
        end
      end
    tests++;
    if (b1.out[0][0] !== 24'h0) begin fails++; $display("FAIL reset_u1 got %h want 0", b1.out[0][0]); end
    tests++;
    if (s_out !== 8'h0) begin fails++; $display("FAIL reset_stall got %h want 0", s_out); end
    tests++;
    if (v_out !== 1'b0) begin fails++; $display("FAIL reset_scalar got %b want 0", v_out); end
    for (int j = 0; j < 2; j++) begin
      tests++;
      if (o2[j] !== 16'h0 || o3[j] !== 16'h0) begin
        fails++;
        $display("FAIL reset_dff2[%0d] got %h/%h want 0/0", j, o2[j], o3[j]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_latency;
    b3.en = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) b3.in[i][j] = 24'(16 * i + j);
    for (int n = 1; n <= 4; n++) begin
      tick();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) b3.in[i][j] = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          tests++;
          if (b3.out[i][j] !== ((n == 3) ? 24'(16 * i + j) : 24'h0)) begin
            fails++;
            $display("FAIL latency c%0d [%0d][%0d] got %h want %h", n, i, j, b3.out[i][j],
                     (n == 3) ? 24'(16 * i + j) : 24'h0);
          end
        end
    end
  endtask

  task automatic test_reset_mid;
    b3.en = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) b3.in[i][j] = 24'hFFFFFF;
    repeat (3) tick();
    tests++;
    if (b3.out[2][1] !== 24'hFFFFFF) begin fails++; $display("FAIL fill got %h want ffffff", b3.out[2][1]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        tests++;
        if (b3.out[i][j] !== 24'h0) begin
          fails++;
          $display("FAIL midreset [%0d][%0d] got %h want 0", i, j, b3.out[i][j]);
        end
        b3.in[i][j] = 24'h100000 + 24'(16 * i + j);
      end
    for (int n = 1; n <= 3; n++) begin
      tick();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          tests++;
          if (b3.out[i][j] !== ((n == 3) ? 24'h100000 + 24'(16 * i + j) : 24'h0)) begin
            fails++;
            $display("FAIL postreset c%0d [%0d][%0d] got %h", n, i, j, b3.out[i][j]);
          end
        end
    end
  endtask

  task automatic test_stall;
    logic [7:0] ins [6] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd4, 8'd0};
    logic ens [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] exp [6] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      s_in = ins[n];
      s_en = ens[n];
      tick();
      tests++;
      if (s_out !== exp[n]) begin fails++; $display("FAIL stall step%0d got %0d want %0d", n, s_out, exp[n]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] p1 [2];
    logic [15:0] p2 [2];
    logic [15:0] cur [2];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r_en = 1'b1;
    p1 = '{16'h0, 16'h0};
    p2 = '{16'h0, 16'h0};
    for (int n = 0; n < 1000; n++) begin
      for (int j = 0; j < 2; j++) cur[j] = 16'($urandom);
      r_in = cur;
      tick();
      for (int j = 0; j < 2; j++) begin
        tests++;
        if (o2[j] !== p1[j] || o3[j] !== p2[j]) begin
          fails++;
          $display("FAIL skew n%0d [%0d] got d2=%h d3=%h want %h %h", n, j, o2[j], o3[j], p1[j], p2[j]);
        end
      end
      p2 = p1;
      p1 = cur;
    end
  endtask

  task automatic test_passthrough;
    logic [23:0] e [3][3];
    rst = 1'b1;
    b0.en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          e[i][j] = 24'($urandom);
          b0.in[i][j] = e[i][j];
        end
      #1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          tests++;
          if (b0.out[i][j] !== e[i][j]) begin
            fails++;
            $display("FAIL passthru n%0d [%0d][%0d] got %h want %h", n, i, j, b0.out[i][j], e[i][j]);
          end
        end
      if (n % 2 == 1) tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_signed;
    logic signed [23:0] m5 = -24'sd5;
    logic [0:0] bits [3] = '{1'b1, 1'b0, 1'b1};
    b1.en = 1'b1;
    b1.in[0][0] = m5;
    tick();
    tests++;
    if (b1.out[0][0] !== 24'hFFFFFB) begin fails++; $display("FAIL signed got %h want fffffb", b1.out[0][0]); end
    v_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      v_in = bits[n];
      tick();
      tests++;
      if (v_out !== bits[n]) begin fails++; $display("FAIL scalar step%0d got %b want %b", n, v_out, bits[n]); end
    end
  endtask

  initial begin
    b3.en = 1'b0;
    b0.en = 1'b0;
    b1.en = 1'b0;
    b1.in[0][0] = '0;
    r_in = '{16'h0, 16'h0};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        b3.in[i][j] = '0;
        b0.in[i][j] = '0;
      end
    test_reset();
    test_latency();
    test_reset_mid();
    test_stall();
    test_back_to_back();
    test_passthrough();
    test_signed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
